// File: rtl/cnn_layer_accel_dispatch_pkg.sv
// Shared types and helpers for the CNN layer accelerator job dispatcher.
// Holds the per-quad and dispatcher state encodings, the width of the
// completed-job counter and a pointer-width helper used to size the
// round-robin and FIFO pointers.
package cnn_layer_accel_dispatch_pkg;

    typedef enum logic [1:0] {
        Q_IDLE  = 2'd0,
        Q_START = 2'd1,
        Q_RUN   = 2'd2,
        Q_ACK   = 2'd3
    } quad_state_t;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_ISSUE = 2'd1,
        D_WAIT  = 2'd2
    } disp_state_t;

    localparam int JOBS_DONE_W = 32;

    // Index width for n entries; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_arb.sv
// Combinational round-robin picker.
// Grants the first asserted request at or after ptr, searching cyclically.
// Ports:
//   req       C_N-bit request vector
//   ptr       search start index (must be < C_N)
//   gnt       one-hot grant (zero when nothing requests)
//   gnt_idx   index of the granted request
//   gnt_valid 1 when any request was granted
module cnn_layer_accel_rr_arb
    import cnn_layer_accel_dispatch_pkg::*;
#(
    parameter int C_N = 4,
    localparam int PW = ptr_width(C_N)
) (
    input  logic [C_N-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [C_N-1:0] gnt,
    output logic [PW-1:0]  gnt_idx,
    output logic           gnt_valid
);

    logic [PW-1:0] cand;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < C_N; i++) begin
            cand = PW'((int'(ptr) + i) % C_N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cnn_layer_accel_job_dispatch.sv
// Job dispatcher for C_NUM_QUADS CNN layer quads.
// Buffers host job words in a FIFO and hands each one to the next idle quad
// in round-robin order, or to every quad at once for broadcast jobs. Runs the
// per-quad start/accept and complete/ack handshakes and arbitrates the shared
// fetch path among running quads.
// Ports:
//   clk_if, rst                 clock, synchronous active-high reset
//   job_in_valid/ready/data/bcast   host job input (ready = FIFO not full)
//   job_start/job_accept        per-quad start handshake
//   job_parameters              FIFO head while a start is pending
//   job_fetch_request/ack/complete  shared fetch path arbitration
//   job_complete/job_complete_ack   per-quad completion handshake
//   quad_busy, jobs_done, idle  status
module cnn_layer_accel_job_dispatch
    import cnn_layer_accel_dispatch_pkg::*;
#(
    parameter int C_NUM_QUADS   = 4,
    parameter int C_JOB_WIDTH   = 128,
    parameter int C_QUEUE_DEPTH = 8
) (
    input  logic                   clk_if,
    input  logic                   rst,
    input  logic                   job_in_valid,
    output logic                   job_in_ready,
    input  logic [C_JOB_WIDTH-1:0] job_in_data,
    input  logic                   job_in_bcast,
    output logic [C_NUM_QUADS-1:0] job_start,
    input  logic [C_NUM_QUADS-1:0] job_accept,
    output logic [C_JOB_WIDTH-1:0] job_parameters,
    input  logic [C_NUM_QUADS-1:0] job_fetch_request,
    output logic [C_NUM_QUADS-1:0] job_fetch_ack,
    input  logic [C_NUM_QUADS-1:0] job_fetch_complete,
    input  logic [C_NUM_QUADS-1:0] job_complete,
    output logic [C_NUM_QUADS-1:0] job_complete_ack,
    output logic [C_NUM_QUADS-1:0] quad_busy,
    output logic [JOBS_DONE_W-1:0] jobs_done,
    output logic                   idle
);

    localparam int QPW = ptr_width(C_NUM_QUADS);
    localparam int AW  = ptr_width(C_QUEUE_DEPTH);
    localparam int CW  = AW + 1;

    function automatic logic [QPW-1:0] wrap_inc(input logic [QPW-1:0] v);
        return (v == QPW'(C_NUM_QUADS - 1)) ? '0 : v + QPW'(1);
    endfunction

    // FIFO
    logic [C_JOB_WIDTH-1:0] fifo_data  [C_QUEUE_DEPTH];
    logic                   fifo_bcast [C_QUEUE_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, count_next;
    logic                   push, pop, head_ok, head_bcast;
    logic [C_JOB_WIDTH-1:0] head_data;

    // Quads
    quad_state_t            q_state [C_NUM_QUADS];
    quad_state_t            q_next  [C_NUM_QUADS];
    logic [C_NUM_QUADS-1:0] idle_mask, start_mask, stay_run, next_idle_mask;
    logic [C_NUM_QUADS-1:0] start_d, cack_d, busy_d, select;
    logic [JOBS_DONE_W-1:0] done_inc;

    // Dispatcher
    disp_state_t            disp_state, disp_next;
    logic [QPW-1:0]         rr_ptr, issue_idx, tgt_idx;
    logic [C_NUM_QUADS-1:0] tgt_gnt;
    logic                   tgt_valid, issue_ok, all_idle;

    // Fetch arbiter
    logic                   owner_valid, owner_release, can_grant;
    logic [QPW-1:0]         owner_idx, fetch_ptr, fetch_arb_ptr, fgnt_idx;
    logic [C_NUM_QUADS-1:0] owner_mask, fetch_req, fgnt;
    logic                   fgnt_valid;

    assign push         = job_in_valid && job_in_ready;
    assign job_in_ready = (count != CW'(C_QUEUE_DEPTH));
    assign head_ok      = (count != '0);
    assign head_bcast   = fifo_bcast[rd_ptr];
    assign head_data    = fifo_data[rd_ptr];
    assign count_next   = count + CW'(push) - CW'(pop);

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_if) begin
        if (push) begin
            fifo_data[wr_ptr]  <= job_in_data;
            fifo_bcast[wr_ptr] <= job_in_bcast;
        end
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    // Per-quad status derived from the current state.
    always_comb begin
        idle_mask  = '0;
        start_mask = '0;
        for (int i = 0; i < C_NUM_QUADS; i++) begin
            idle_mask[i]  = (q_state[i] == Q_IDLE);
            start_mask[i] = (q_state[i] == Q_START);
        end
    end

    assign all_idle = &idle_mask;

    // Dispatch target: first idle quad at or after rr_ptr.
    cnn_layer_accel_rr_arb #(.C_N(C_NUM_QUADS)) u_disp_arb (
        .req       (idle_mask),
        .ptr       (rr_ptr),
        .gnt       (tgt_gnt),
        .gnt_idx   (tgt_idx),
        .gnt_valid (tgt_valid)
    );

    // Dispatcher state register plus the job_parameters/rr_ptr bookkeeping.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            disp_state     <= D_IDLE;
            rr_ptr         <= '0;
            issue_idx      <= '0;
            job_parameters <= '0;
        end else begin
            disp_state <= disp_next;
            if (issue_ok) begin
                issue_idx      <= tgt_idx;
                job_parameters <= head_data;
            end
            if (pop && !head_bcast) rr_ptr <= wrap_inc(issue_idx);
        end
    end

    // Dispatcher next state. Issue straight from D_IDLE so a freshly pushed
    // job reaches job_start two cycles after the push.
    always_comb begin
        disp_next = disp_state;
        case (disp_state)
            D_IDLE, D_ISSUE: begin
                if (issue_ok)     disp_next = D_WAIT;
                else if (head_ok) disp_next = D_ISSUE;
                else              disp_next = D_IDLE;
            end
            D_WAIT: begin
                if (pop) disp_next = (count > CW'(1)) ? D_ISSUE : D_IDLE;
            end
            default: disp_next = D_IDLE;
        endcase
    end

    // Dispatcher outputs. Only quads selected for the head job sit in Q_START,
    // so the job is fully accepted once no Q_START quad is left unaccepted.
    always_comb begin
        issue_ok = 1'b0;
        select   = '0;
        pop      = 1'b0;
        case (disp_state)
            D_IDLE, D_ISSUE: begin
                if (head_ok && (head_bcast ? all_idle : tgt_valid)) begin
                    issue_ok = 1'b1;
                    select   = head_bcast ? '1 : tgt_gnt;
                end
            end
            D_WAIT: pop = ((start_mask & ~job_accept) == '0);
            default: ;
        endcase
    end

    // Quad state registers and their registered handshake outputs.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_QUADS; i++) q_state[i] <= Q_IDLE;
            job_start        <= '0;
            job_complete_ack <= '0;
            quad_busy        <= '0;
            jobs_done        <= '0;
            idle             <= 1'b1;
        end else begin
            for (int i = 0; i < C_NUM_QUADS; i++) q_state[i] <= q_next[i];
            job_start        <= start_d;
            job_complete_ack <= cack_d;
            quad_busy        <= busy_d;
            jobs_done        <= jobs_done + done_inc;
            idle             <= (count_next == '0) && (&next_idle_mask);
        end
    end

    // Quad next state; stray accepts and completes fall through unchanged.
    always_comb begin
        for (int i = 0; i < C_NUM_QUADS; i++) begin
            q_next[i] = q_state[i];
            case (q_state[i])
                Q_IDLE:  if (select[i])       q_next[i] = Q_START;
                Q_START: if (job_accept[i])   q_next[i] = Q_RUN;
                Q_RUN:   if (job_complete[i]) q_next[i] = Q_ACK;
                Q_ACK:                        q_next[i] = Q_IDLE;
            endcase
        end
    end

    // Next values of the registered quad outputs.
    always_comb begin
        start_d        = '0;
        cack_d         = '0;
        busy_d         = '0;
        next_idle_mask = '0;
        stay_run       = '0;
        done_inc       = '0;
        for (int i = 0; i < C_NUM_QUADS; i++) begin
            start_d[i]        = (q_next[i] == Q_START);
            cack_d[i]         = (q_next[i] == Q_ACK);
            busy_d[i]         = (q_next[i] != Q_IDLE);
            next_idle_mask[i] = (q_next[i] == Q_IDLE);
            stay_run[i]       = (q_state[i] == Q_RUN) && (q_next[i] == Q_RUN);
            if (q_state[i] == Q_RUN && job_complete[i])
                done_inc = done_inc + JOBS_DONE_W'(1);
        end
    end

    // Fetch ownership ends on fetch complete or when the owner leaves Q_RUN.
    // On release the search restarts just past the old owner in the same
    // cycle, so the next requester is granted without a dead cycle.
    always_comb begin
        owner_mask    = owner_valid ? (C_NUM_QUADS'(1) << owner_idx) : '0;
        owner_release = owner_valid &&
                        (job_fetch_complete[owner_idx] || !stay_run[owner_idx]);
        can_grant     = !owner_valid || owner_release;
        fetch_req     = job_fetch_request & stay_run & ~owner_mask;
        fetch_arb_ptr = owner_release ? wrap_inc(owner_idx) : fetch_ptr;
    end

    cnn_layer_accel_rr_arb #(.C_N(C_NUM_QUADS)) u_fetch_arb (
        .req       (fetch_req),
        .ptr       (fetch_arb_ptr),
        .gnt       (fgnt),
        .gnt_idx   (fgnt_idx),
        .gnt_valid (fgnt_valid)
    );

    // Fetch owner register and registered grant.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            owner_valid   <= 1'b0;
            owner_idx     <= '0;
            fetch_ptr     <= '0;
            job_fetch_ack <= '0;
        end else begin
            if (owner_release) fetch_ptr <= wrap_inc(owner_idx);
            if (can_grant && fgnt_valid) begin
                owner_valid   <= 1'b1;
                owner_idx     <= fgnt_idx;
                job_fetch_ack <= fgnt;
            end else if (owner_release) begin
                owner_valid   <= 1'b0;
                job_fetch_ack <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_job_dispatch.sv
// Directed self-checking bench for cnn_layer_accel_job_dispatch (4 quads,
// 128-bit jobs, 8-deep FIFO). Inputs change 1ns after the rising edge and
// outputs are sampled at that same point.
module tb_cnn_layer_accel_job_dispatch;

    localparam int NQ = 4;
    localparam int JW = 128;

    logic          clk_if = 1'b0;
    logic          rst;
    logic          job_in_valid;
    logic          job_in_ready;
    logic [JW-1:0] job_in_data;
    logic          job_in_bcast;
    logic [NQ-1:0] job_start;
    logic [NQ-1:0] job_accept;
    logic [JW-1:0] job_parameters;
    logic [NQ-1:0] job_fetch_request;
    logic [NQ-1:0] job_fetch_ack;
    logic [NQ-1:0] job_fetch_complete;
    logic [NQ-1:0] job_complete;
    logic [NQ-1:0] job_complete_ack;
    logic [NQ-1:0] quad_busy;
    logic [31:0]   jobs_done;
    logic          idle;

    int total = 0;
    int bad   = 0;

    logic [NQ-1:0] accept_en;
    bit            complete_auto;
    logic [NQ-1:0] log_mask [$];
    logic [JW-1:0] log_par  [$];
    logic [NQ-1:0] seen;
    bit            found;

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_job_dispatch #(
        .C_NUM_QUADS   (NQ),
        .C_JOB_WIDTH   (JW),
        .C_QUEUE_DEPTH (8)
    ) dut (
        .clk_if             (clk_if),
        .rst                (rst),
        .job_in_valid       (job_in_valid),
        .job_in_ready       (job_in_ready),
        .job_in_data        (job_in_data),
        .job_in_bcast       (job_in_bcast),
        .job_start          (job_start),
        .job_accept         (job_accept),
        .job_parameters     (job_parameters),
        .job_fetch_request  (job_fetch_request),
        .job_fetch_ack      (job_fetch_ack),
        .job_fetch_complete (job_fetch_complete),
        .job_complete       (job_complete),
        .job_complete_ack   (job_complete_ack),
        .quad_busy          (quad_busy),
        .jobs_done          (jobs_done),
        .idle               (idle)
    );

    function automatic logic [JW-1:0] mk(input int k);
        return {32'hA5A5_0000 | 32'(k), 96'h1234_5678_9ABC_DEF0_0F1E_2D3C};
    endfunction

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [JW-1:0] got,
                               input logic [JW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        rst                = 1'b1;
        job_in_valid       = 1'b0;
        job_in_data        = '0;
        job_in_bcast       = 1'b0;
        job_accept         = '0;
        job_fetch_request  = '0;
        job_fetch_complete = '0;
        job_complete       = '0;
        accept_en          = '0;
        complete_auto      = 1'b0;
        log_mask.delete();
        log_par.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Quads accept any start on enabled lanes the cycle they see it; each
    // accepted start is logged with its parameter word.
    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            job_accept   = job_start & accept_en;
            job_complete = complete_auto ? '1 : '0;
            if ((job_start & accept_en) != '0) begin
                log_mask.push_back(job_start);
                log_par.push_back(job_parameters);
            end
            tick();
        end
        job_accept   = '0;
        job_complete = '0;
    endtask

    task automatic applyStimulus(input logic [JW-1:0] d, input logic b);
        job_in_valid = 1'b1;
        job_in_data  = d;
        job_in_bcast = b;
        runCycles(1);
        job_in_valid = 1'b0;
        job_in_bcast = 1'b0;
    endtask

    task automatic waitStart(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (job_start != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, " job_start"},        job_start, 0);
        checkOutput({pfx, " job_fetch_ack"},    job_fetch_ack, 0);
        checkOutput({pfx, " job_complete_ack"}, job_complete_ack, 0);
        checkOutput({pfx, " quad_busy"},        quad_busy, 0);
        checkOutput({pfx, " jobs_done"},        jobs_done, 0);
        checkOutput({pfx, " job_parameters"},   job_parameters, 0);
        checkOutput({pfx, " job_in_ready"},     job_in_ready, 1);
        checkOutput({pfx, " idle"},             idle, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        doReset();
        checkResetValues("reset");

        // Single normal job to quad 0
        job_in_valid = 1'b1;
        job_in_data  = mk(100);
        tick();
        job_in_valid = 1'b0;
        checkOutput("single idle after push", idle, 0);
        checkOutput("single start t+1", job_start, 0);
        tick();
        checkOutput("single start t+2", job_start, 4'b0001);
        checkOutput("single params", job_parameters, mk(100));
        checkOutput("single busy", quad_busy, 4'b0001);
        tick();
        job_accept = 4'b0001;
        tick();
        job_accept = '0;
        checkOutput("single start dropped", job_start, 0);
        checkOutput("single busy run", quad_busy, 4'b0001);
        job_complete = 4'b0001;
        tick();
        job_complete = '0;
        checkOutput("single ack high", job_complete_ack, 4'b0001);
        tick();
        checkOutput("single ack low", job_complete_ack, 0);
        checkOutput("single busy low", quad_busy, 0);
        checkOutput("single jobs_done", jobs_done, 1);
        checkOutput("single idle", idle, 1);

        // Five normal jobs, round robin
        doReset();
        accept_en = '1;
        for (int k = 1; k <= 5; k++) applyStimulus(mk(k), 1'b0);
        runCycles(10);
        checkOutput("rr issued count", log_mask.size(), 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rr mask %0d", k), log_mask[k], 4'b0001 << k);
            checkOutput($sformatf("rr params %0d", k), log_par[k], mk(k + 1));
        end
        checkOutput("rr all busy", quad_busy, 4'b1111);
        checkOutput("rr job5 held", job_start, 0);
        job_complete = 4'b0010;
        tick();
        job_complete = '0;
        runCycles(8);
        checkOutput("rr issued count 5", log_mask.size(), 5);
        checkOutput("rr job5 mask", log_mask[4], 4'b0010);
        checkOutput("rr job5 params", log_par[4], mk(5));
        checkOutput("rr jobs_done", jobs_done, 1);

        // Broadcast waits for quad 2
        doReset();
        accept_en = '1;
        for (int k = 1; k <= 3; k++) applyStimulus(mk(20 + k), 1'b0);
        runCycles(6);
        job_complete = 4'b0011;
        tick();
        job_complete = '0;
        runCycles(3);
        accept_en = '0;
        applyStimulus(mk(30), 1'b1);
        applyStimulus(mk(31), 1'b0);
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | job_start;
            tick();
        end
        checkOutput("bcast no start while q2 busy", seen, 0);
        job_complete = 4'b0100;
        tick();
        job_complete = '0;
        checkOutput("bcast q2 ack", job_complete_ack, 4'b0100);
        checkOutput("bcast start t+1", job_start, 0);
        tick();
        checkOutput("bcast start t+2", job_start, 0);
        tick();
        checkOutput("bcast start all", job_start, 4'b1111);
        checkOutput("bcast params", job_parameters, mk(30));
        job_accept = 4'b0001;
        tick();
        checkOutput("bcast stagger 1", job_start, 4'b1110);
        job_accept = 4'b0110;
        tick();
        checkOutput("bcast stagger 2", job_start, 4'b1000);
        job_accept = 4'b1000;
        tick();
        job_accept = '0;
        checkOutput("bcast stagger 3", job_start, 0);
        checkOutput("bcast all busy", quad_busy, 4'b1111);
        checkOutput("bcast jobs_done", jobs_done, 3);
        job_complete = 4'b1001;
        tick();
        job_complete = '0;
        checkOutput("bcast dual complete", jobs_done, 5);
        waitStart(10, found);
        checkOutput("bcast next start seen", found, 1);
        checkOutput("bcast next mask rr kept", job_start, 4'b1000);
        checkOutput("bcast next params", job_parameters, mk(31));

        // Fill FIFO while quad 0 stalls in Q_START
        doReset();
        for (int k = 1; k <= 8; k++) applyStimulus(mk(40 + k), 1'b0);
        checkOutput("full ready low", job_in_ready, 0);
        checkOutput("full q0 stalled", job_start, 4'b0001);
        applyStimulus(mk(49), 1'b0);
        checkOutput("full ready after 9th", job_in_ready, 0);
        accept_en     = '1;
        complete_auto = 1'b1;
        runCycles(60);
        complete_auto = 1'b0;
        checkOutput("full drained count", log_par.size(), 8);
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("full order %0d", k), log_par[k], mk(41 + k));
        checkOutput("full jobs_done", jobs_done, 8);
        checkOutput("full ready back", job_in_ready, 1);
        checkOutput("full idle", idle, 1);

        // Fetch arbitration between quads 1 and 3
        doReset();
        accept_en = '1;
        for (int k = 1; k <= 4; k++) applyStimulus(mk(60 + k), 1'b0);
        runCycles(8);
        accept_en = '0;
        checkOutput("fetch all running", quad_busy, 4'b1111);
        job_fetch_request = 4'b1010;
        tick();
        checkOutput("fetch grant q1", job_fetch_ack, 4'b0010);
        tick();
        checkOutput("fetch q1 held", job_fetch_ack, 4'b0010);
        job_fetch_complete = 4'b0010;
        job_fetch_request  = 4'b1000;
        tick();
        job_fetch_complete = '0;
        checkOutput("fetch grant q3", job_fetch_ack, 4'b1000);
        tick();
        checkOutput("fetch q3 held", job_fetch_ack, 4'b1000);
        job_fetch_complete = 4'b1000;
        job_fetch_request  = '0;
        tick();
        job_fetch_complete = '0;
        checkOutput("fetch released", job_fetch_ack, 0);
        job_complete = 4'b1010;
        tick();
        job_complete = '0;
        checkOutput("fetch dual ack", job_complete_ack, 4'b1010);
        checkOutput("fetch jobs_done", jobs_done, 2);

        // Reset mid-operation
        doReset();
        accept_en = '1;
        applyStimulus(mk(70), 1'b0);
        applyStimulus(mk(71), 1'b0);
        runCycles(4);
        accept_en = '0;
        for (int k = 2; k <= 4; k++) applyStimulus(mk(70 + k), 1'b0);
        runCycles(2);
        checkOutput("midrst busy before", quad_busy, 4'b0111);
        checkOutput("midrst idle before", idle, 0);
        rst = 1'b1;
        tick();
        checkResetValues("midrst");
        rst = 1'b0;
        runCycles(4);
        checkOutput("midrst no start after", job_start, 0);
        checkOutput("midrst idle after", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
